// File: rtl/apb_uart_pkg.sv
// Shared register offsets, STATUS/CTRL bit positions and FSM encodings for the APB UART slave.
// Parity support in the users of this package is selected by the UART_PARITY_EN macro.
package apb_uart_pkg;

    localparam logic [1:0] REG_DATA   = 2'd0;
    localparam logic [1:0] REG_STATUS = 2'd1;
    localparam logic [1:0] REG_DIV    = 2'd2;
    localparam logic [1:0] REG_CTRL   = 2'd3;

    localparam int STAT_TXFULL   = 0;
    localparam int STAT_TXEMPTY  = 1;
    localparam int STAT_RXFULL   = 2;
    localparam int STAT_RXEMPTY  = 3;
    localparam int STAT_TXBUSY   = 4;
    localparam int STAT_OVERRUN  = 5;
    localparam int STAT_FRAMING  = 6;
    localparam int STAT_PARITY   = 7;

    localparam int CTRL_EN      = 0;
    localparam int CTRL_IE_RX   = 1;
    localparam int CTRL_IE_TX   = 2;
    localparam int CTRL_IE_ERR  = 3;
    localparam int CTRL_PAR_ODD = 4;

    // Sticky flag vector holds {parity, framing, overrun}
    localparam int FLAG_OVERRUN = 0;
    localparam int FLAG_FRAMING = 1;
    localparam int FLAG_PARITY  = 2;

    localparam logic [15:0] MIN_DIV = 16'd4;

    typedef enum logic [2:0] {
        UART_IDLE,
        UART_START,
        UART_DATA,
        UART_PARITY,
        UART_STOP
    } uart_state_t;

    function automatic logic [15:0] clamp_div(input logic [15:0] value);
        return (value < MIN_DIV) ? MIN_DIV : value;
    endfunction

endpackage

// File: rtl/uart_sync_fifo.sv
// Single-clock first-word-fall-through FIFO with occupancy count, full and empty flags.
// A push while full is accepted only when a pop frees a slot in the same cycle.
module uart_sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         push_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         pop_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop & ~empty;
    assign do_push  = push & (~full | do_pop);
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/apb_uart_fifo_slave.sv
// APB UART slave with TX/RX FIFOs, programmable divisor, bounded wait states and sticky error flags.
// Define UART_PARITY_EN to add a parity bit (even, or odd when CTRL.par_odd=1) to both directions.
module apb_uart_fifo_slave
    import apb_uart_pkg::*;
#(
    parameter int ADDR_W      = 5,
    parameter int DATA_BITS   = 8,
    parameter int TX_DEPTH    = 8,
    parameter int RX_DEPTH    = 8,
    parameter int DEFAULT_DIV = 10417,
    parameter int TIMEOUT     = 16
) (
    input  logic              pclk,
    input  logic              Reset,
    input  logic              psel,
    input  logic              penable,
    input  logic              pwrite,
    input  logic [ADDR_W-1:0] paddr,
    input  logic [31:0]       pwdata,
    output logic [31:0]       prdata,
    output logic              pready,
    output logic              pslverr,
    input  logic              rx,
    output logic              tx,
    output logic              irq
);

    localparam int WAIT_W = $clog2(TIMEOUT + 1);
`ifdef UART_PARITY_EN
    localparam logic [4:0] CTRL_MASK = 5'h1F;
`else
    localparam logic [4:0] CTRL_MASK = 5'h0F;
`endif

    logic [1:0]            reg_addr;
    logic                  access;
    logic                  is_data;
    logic                  blocked;
    logic                  timed_out;
    logic                  reg_wr;
    logic [WAIT_W-1:0]     wait_cnt;
    logic [15:0]           div_reg;
    logic [4:0]            ctrl;
    logic [2:0]            flags;
    logic [2:0]            flag_clr;
    logic [7:0]            status;

    logic                  tx_push;
    logic                  tx_pop;
    logic [DATA_BITS-1:0]  tx_head;
    logic [$clog2(TX_DEPTH):0] tx_count;
    logic                  tx_full;
    logic                  tx_empty;

    logic                  rx_push;
    logic                  rx_pop;
    logic [DATA_BITS-1:0]  rx_head;
    logic [$clog2(RX_DEPTH):0] rx_count;
    logic                  rx_full;
    logic                  rx_empty;

    uart_state_t           tx_state;
    logic [15:0]           tx_cnt;
    logic [3:0]            tx_bit;
    logic [DATA_BITS-1:0]  tx_shift;
    logic                  tx_start;

    uart_state_t           rx_state;
    logic [1:0]            rx_sync;
    logic                  rx_s;
    logic                  rx_prev;
    logic [15:0]           rx_cnt;
    logic [3:0]            rx_bit;
    logic [DATA_BITS-1:0]  rx_shift;
`ifdef UART_PARITY_EN
    logic                  tx_par;
    logic                  rx_par_err;
`endif

    logic                  unused_bits;
    assign unused_bits = ^{paddr[ADDR_W-1:4], paddr[1:0], pwdata[31:16], tx_count, rx_count};

    // A DATA access stalls while its FIFO cannot serve it, until the wait budget runs out
    assign reg_addr  = paddr[3:2];
    assign access    = psel & penable;
    assign is_data   = (reg_addr == REG_DATA);
    assign blocked   = is_data & (pwrite ? tx_full : rx_empty);
    assign timed_out = (wait_cnt == WAIT_W'(TIMEOUT));
    assign pready    = access & (~blocked | timed_out);
    assign pslverr   = access & blocked & timed_out;
    assign reg_wr    = access & pwrite & pready;

    assign tx_push  = access & pwrite & is_data & ~tx_full;
    assign rx_pop   = access & ~pwrite & is_data & ~rx_empty;
    assign flag_clr = (reg_wr && reg_addr == REG_STATUS) ? pwdata[7:5] : 3'b000;

    always_comb begin
        status               = 8'h00;
        status[STAT_TXFULL]  = tx_full;
        status[STAT_TXEMPTY] = tx_empty;
        status[STAT_RXFULL]  = rx_full;
        status[STAT_RXEMPTY] = rx_empty;
        status[STAT_TXBUSY]  = (tx_state != UART_IDLE);
        status[STAT_OVERRUN] = flags[FLAG_OVERRUN];
        status[STAT_FRAMING] = flags[FLAG_FRAMING];
        status[STAT_PARITY]  = flags[FLAG_PARITY];
    end

    always_comb begin
        prdata = 32'h0;
        if (access && pready && !pslverr && !pwrite) begin
            case (reg_addr)
                REG_DATA:   prdata[DATA_BITS-1:0] = rx_head;
                REG_STATUS: prdata[7:0]           = status;
                REG_DIV:    prdata[15:0]          = div_reg;
                default:    prdata[4:0]           = ctrl;
            endcase
        end
    end

    always_ff @(posedge pclk) begin
        if (Reset) begin
            wait_cnt <= '0;
            div_reg  <= 16'(DEFAULT_DIV);
            ctrl     <= 5'h00;
            irq      <= 1'b0;
        end else begin
            if (!access || pready) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + 1'b1;
            end
            if (reg_wr && reg_addr == REG_DIV) begin
                div_reg <= clamp_div(pwdata[15:0]);
            end
            if (reg_wr && reg_addr == REG_CTRL) begin
                ctrl <= pwdata[4:0] & CTRL_MASK;
            end
            irq <= (ctrl[CTRL_IE_RX] & ~rx_empty) |
                   (ctrl[CTRL_IE_TX] & tx_empty) |
                   (ctrl[CTRL_IE_ERR] & (|flags));
        end
    end

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk       (pclk),
        .reset     (Reset),
        .push      (tx_push),
        .push_data (pwdata[DATA_BITS-1:0]),
        .pop       (tx_pop),
        .pop_data  (tx_head),
        .count     (tx_count),
        .full      (tx_full),
        .empty     (tx_empty)
    );

    uart_sync_fifo #(.WIDTH(DATA_BITS), .DEPTH(RX_DEPTH)) u_rx_fifo (
        .clk       (pclk),
        .reset     (Reset),
        .push      (rx_push),
        .push_data (rx_shift),
        .pop       (rx_pop),
        .pop_data  (rx_head),
        .count     (rx_count),
        .full      (rx_full),
        .empty     (rx_empty)
    );

    // A new frame may start from IDLE or straight out of the last stop-bit cycle, so frames abut
    assign tx_start = ctrl[CTRL_EN] & ~tx_empty &
                      ((tx_state == UART_IDLE) || (tx_state == UART_STOP && tx_cnt == 16'd0));
    assign tx_pop   = tx_start;

    always_ff @(posedge pclk) begin
        if (Reset) begin
            tx_state <= UART_IDLE;
            tx       <= 1'b1;
            tx_cnt   <= 16'd0;
            tx_bit   <= 4'd0;
            tx_shift <= '0;
`ifdef UART_PARITY_EN
            tx_par   <= 1'b0;
`endif
        end else if (tx_start) begin
            tx_state <= UART_START;
            tx       <= 1'b0;
            tx_cnt   <= div_reg - 16'd1;
            tx_shift <= tx_head;
`ifdef UART_PARITY_EN
            tx_par   <= (^tx_head) ^ ctrl[CTRL_PAR_ODD];
`endif
        end else if (tx_state != UART_IDLE && tx_cnt != 16'd0) begin
            tx_cnt <= tx_cnt - 16'd1;
        end else begin
            tx_cnt <= div_reg - 16'd1;
            case (tx_state)
                UART_START: begin
                    tx       <= tx_shift[0];
                    tx_bit   <= 4'd0;
                    tx_state <= UART_DATA;
                end
                UART_DATA: begin
                    if (tx_bit == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                        tx       <= tx_par;
                        tx_state <= UART_PARITY;
`else
                        tx       <= 1'b1;
                        tx_state <= UART_STOP;
`endif
                    end else begin
                        tx_shift <= tx_shift >> 1;
                        tx       <= tx_shift[1];
                        tx_bit   <= tx_bit + 4'd1;
                    end
                end
`ifdef UART_PARITY_EN
                UART_PARITY: begin
                    tx       <= 1'b1;
                    tx_state <= UART_STOP;
                end
`endif
                default: begin
                    tx       <= 1'b1;
                    tx_state <= UART_IDLE;
                end
            endcase
        end
    end

    assign rx_s = rx_sync[1];

    // Every sample point is a counter expiry; errors pick one flag and drop the byte
    always_ff @(posedge pclk) begin
        if (Reset) begin
            rx_sync  <= 2'b11;
            rx_prev  <= 1'b1;
            rx_state <= UART_IDLE;
            rx_cnt   <= 16'd0;
            rx_bit   <= 4'd0;
            rx_shift <= '0;
            rx_push  <= 1'b0;
            flags    <= 3'b000;
`ifdef UART_PARITY_EN
            rx_par_err <= 1'b0;
`endif
        end else begin
            rx_sync <= {rx_sync[0], rx};
            rx_prev <= rx_s;
            rx_push <= 1'b0;
            flags   <= flags & ~flag_clr;
            if (rx_state == UART_IDLE) begin
                if (rx_prev && !rx_s) begin
                    rx_state <= UART_START;
                    rx_cnt   <= (div_reg >> 1) - 16'd1;
                end
            end else if (rx_cnt != 16'd0) begin
                rx_cnt <= rx_cnt - 16'd1;
            end else begin
                rx_cnt <= div_reg - 16'd1;
                case (rx_state)
                    UART_START: begin
                        rx_bit   <= 4'd0;
                        rx_state <= rx_s ? UART_IDLE : UART_DATA;
                    end
                    UART_DATA: begin
                        rx_shift <= {rx_s, rx_shift[DATA_BITS-1:1]};
                        rx_bit   <= rx_bit + 4'd1;
                        if (rx_bit == 4'(DATA_BITS - 1)) begin
`ifdef UART_PARITY_EN
                            rx_state <= UART_PARITY;
`else
                            rx_state <= UART_STOP;
`endif
                        end
                    end
`ifdef UART_PARITY_EN
                    UART_PARITY: begin
                        rx_par_err <= (^rx_shift) ^ rx_s ^ ctrl[CTRL_PAR_ODD];
                        rx_state   <= UART_STOP;
                    end
`endif
                    default: begin
                        rx_state <= UART_IDLE;
                        if (!rx_s) begin
                            flags[FLAG_FRAMING] <= 1'b1;
`ifdef UART_PARITY_EN
                        end else if (rx_par_err) begin
                            flags[FLAG_PARITY] <= 1'b1;
`endif
                        end else if (rx_full) begin
                            flags[FLAG_OVERRUN] <= 1'b1;
                        end else begin
                            rx_push <= 1'b1;
                        end
                    end
                endcase
            end
        end
    end

endmodule
